disp_arbiter: RTL and testbench



---
 rtl/disp_pkg.sv | 25 ++
 rtl/rr_pick.sv | 29 ++
 rtl/disp_arbiter.sv | 110 +++++++++++
 tb/tb_disp_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared constants, FSM encoding and width helper for the display arbiter.
package disp_pkg;

  localparam int unsigned DISP_W       = 16;
  localparam int unsigned HOLD_DEFAULT = 100_000_000;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // Ceiling log2, never below 1 so every derived vector has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned     r;
    longint unsigned v;
    r = 0;
    v = 1;
    while (v < 64'(n)) begin
      v = v << 1;
      r++;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester after rr_last, wrapping modulo NUM_REQ.
module rr_pick
  import disp_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      rr_last,
  output logic [IW-1:0]      winner,
  output logic               any_req
);

  // Scan rr_last+1 .. rr_last+NUM_REQ so the previous owner is considered last.
  always_comb begin
    logic [IW-1:0] idx;
    idx     = '0;
    winner  = '0;
    any_req = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((32'(rr_last) + k) % NUM_REQ);
      if (!any_req && req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/disp_arbiter.sv
// Round-robin owner of the shared 4-digit hex display with a minimum dwell per grant.
module disp_arbiter
  import disp_pkg::*;
#(
  parameter int unsigned       NUM_REQ     = 4,
  parameter int unsigned       HOLD_CYCLES = HOLD_DEFAULT,
  parameter logic [DISP_W-1:0] RESET_WORD  = 16'h0000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DISP_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         ack,
  output logic [DISP_W-1:0]          disp_data,
  output logic [2:0]                 owner,
  output logic                       busy
);

  localparam int unsigned IW         = clog2(NUM_REQ);
  localparam int unsigned TW         = clog2(HOLD_CYCLES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(HOLD_CYCLES - 1);

  state_t              state_q, state_nx;
  logic [TW-1:0]       timer_q, timer_nx;
  logic [IW-1:0]       rr_last_q, rr_last_nx;
  logic [IW-1:0]       owner_q, owner_nx;
  logic [DISP_W-1:0]   data_q, data_nx;
  logic [NUM_REQ-1:0]  ack_q, ack_nx;
  logic [IW-1:0]       winner;
  logic                any_req;
  logic                grant;
  logic [DISP_W-1:0]   words [NUM_REQ];

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_pick (
    .req     (req),
    .rr_last (rr_last_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Unpack the flat request bus into per-requester words.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      words[i] = req_data[i*DISP_W +: DISP_W];
    end
  end

  // State, dwell timer and capture registers; all outputs come straight from here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      rr_last_q <= IW'(NUM_REQ - 1);
      owner_q   <= '0;
      data_q    <= RESET_WORD;
      ack_q     <= '0;
    end else begin
      state_q   <= state_nx;
      timer_q   <= timer_nx;
      rr_last_q <= rr_last_nx;
      owner_q   <= owner_nx;
      data_q    <= data_nx;
      ack_q     <= ack_nx;
    end
  end

  // Next-state: grant from IDLE or at dwell end, in-place owner updates mid-dwell.
  always_comb begin
    state_nx   = state_q;
    timer_nx   = timer_q;
    rr_last_nx = rr_last_q;
    owner_nx   = owner_q;
    data_nx    = data_q;
    ack_nx     = '0;
    grant      = 1'b0;
    unique case (state_q)
      IDLE: grant = any_req;
      SHOW: begin
        if (timer_q == '0) begin
          if (any_req) grant = 1'b1;
          else         state_nx = IDLE;
        end else begin
          timer_nx = timer_q - TW'(1);
          if (req[owner_q]) begin
            data_nx         = words[owner_q];
            ack_nx[owner_q] = 1'b1;
          end
        end
      end
    endcase
    if (grant) begin
      state_nx       = SHOW;
      timer_nx       = TIMER_LOAD;
      rr_last_nx     = winner;
      owner_nx       = winner;
      data_nx        = words[winner];
      ack_nx         = '0;
      ack_nx[winner] = 1'b1;
    end
  end

  assign ack       = ack_q;
  assign disp_data = data_q;
  assign owner     = 3'(owner_q);
  assign busy      = (state_q == SHOW);

endmodule

// File: tb/tb_disp_arbiter.sv
// Self-checking bench for disp_arbiter: vector table, directed corner cases, randomized run vs. timeline model.
module tb_disp_arbiter;

  localparam int          NR = 4;
  localparam int          H  = 8;
  localparam logic [15:0] RW = 16'h0000;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR*16-1:0]  req_data;
  logic [NR-1:0]     ack;
  logic [15:0]       disp_data;
  logic [2:0]        owner;
  logic              busy;

  always #5 clk = ~clk;

  disp_arbiter #(
    .NUM_REQ     (NR),
    .HOLD_CYCLES (H),
    .RESET_WORD  (RW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .disp_data (disp_data),
    .owner     (owner),
    .busy      (busy)
  );

  int checks = 0;
  int passed = 0;
  int edge_n = 0;

  // Reference model: the dwell is tracked as the absolute edge number of the last grant.
  bit          m_show;
  int          m_gedge;
  int          m_owner;
  int          m_last;
  logic [15:0] m_data;
  logic [NR-1:0] m_ack;

  typedef struct {
    bit            rst;
    logic [NR-1:0] rq;
    logic [15:0]   word2;
    logic [NR-1:0] e_ack;
    logic [15:0]   e_data;
    logic [2:0]    e_owner;
    bit            e_busy;
  } vec_t;

  vec_t vt [10];

  function automatic logic [15:0] word_of(input int i);
    return req_data[16*i +: 16];
  endfunction

  task automatic set_word(input int i, input logic [15:0] w);
    req_data[16*i +: 16] = w;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, edge_n, got, exp);
  endtask

  task automatic model_edge();
    int w;
    m_ack = '0;
    if (reset) begin
      m_show  = 1'b0;
      m_gedge = 0;
      m_owner = 0;
      m_last  = NR - 1;
      m_data  = RW;
      return;
    end
    w = -1;
    for (int k = 1; k <= NR; k++) begin
      if (w < 0 && req[(m_last + k) % NR]) w = (m_last + k) % NR;
    end
    if (!m_show || edge_n == m_gedge + H) begin
      if (w >= 0) begin
        m_show   = 1'b1;
        m_gedge  = edge_n;
        m_owner  = w;
        m_last   = w;
        m_data   = word_of(w);
        m_ack[w] = 1'b1;
      end else begin
        m_show = 1'b0;
      end
    end else if (req[m_owner]) begin
      m_data         = word_of(m_owner);
      m_ack[m_owner] = 1'b1;
    end
  endtask

  task automatic tick();
    edge_n++;
    model_edge();
    @(posedge clk);
    #1;
    check("ack", 32'(ack), 32'(m_ack));
    check("disp_data", 32'(disp_data), 32'(m_data));
    check("owner", 32'(owner), 32'(m_owner));
    check("busy", 32'(busy), 32'(m_show));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gown[$];
    int gedge[$];
    int n;

    vt[0] = '{1'b0, 4'b0100, 16'hBEEF, 4'b0100, 16'hBEEF, 3'd2, 1'b1};
    for (int k = 1; k <= 7; k++) vt[k] = '{1'b0, 4'b0000, 16'hBEEF, 4'b0000, 16'hBEEF, 3'd2, 1'b1};
    vt[8] = '{1'b0, 4'b0000, 16'hBEEF, 4'b0000, 16'hBEEF, 3'd2, 1'b0};
    vt[9] = '{1'b0, 4'b0000, 16'hBEEF, 4'b0000, 16'hBEEF, 3'd2, 1'b0};

    reset    = 1'b1;
    req      = '0;
    req_data = '0;
    tick();
    tick();
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_data", 32'(disp_data), 32'(RW));
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("idle_ack", 32'(ack), 32'h0);
      check("idle_data", 32'(disp_data), 32'h0);
      check("idle_owner", 32'(owner), 32'h0);
      check("idle_busy", 32'(busy), 32'h0);
    end

    // Single request from IDLE, one table row per edge.
    for (int k = 0; k < 10; k++) begin
      reset = vt[k].rst;
      req   = vt[k].rq;
      set_word(2, vt[k].word2);
      tick();
      check("tbl_ack", 32'(ack), 32'(vt[k].e_ack));
      check("tbl_data", 32'(disp_data), 32'(vt[k].e_data));
      check("tbl_owner", 32'(owner), 32'(vt[k].e_owner));
      check("tbl_busy", 32'(busy), 32'(vt[k].e_busy));
    end

    // Fairness: everyone requesting, each re-requests once it no longer owns the display.
    do_reset();
    for (int i = 0; i < NR; i++) set_word(i, 16'(i));
    req = '1;
    for (int c = 0; c < 36; c++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (ack[i]) begin
          gown.push_back(i);
          gedge.push_back(edge_n);
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i] && 32'(owner) != i) req[i] = 1'b1;
      end
    end
    check("fair_count", 32'(gown.size()), 32'd5);
    for (int k = 0; k < gown.size() && k < 5; k++) begin
      check("fair_order", 32'(gown[k]), 32'(k % NR));
      if (k > 0) check("fair_gap", 32'(gedge[k] - gedge[k-1]), 32'(H));
    end

    // Owner updates in place mid-dwell while requester 3 waits.
    do_reset();
    set_word(1, 16'h1111);
    req[1] = 1'b1;
    tick();
    check("b_grant_ack", 32'(ack), 32'b0010);
    req[1] = 1'b0;
    set_word(3, 16'h3333);
    req[3] = 1'b1;
    repeat (4) tick();
    set_word(1, 16'h1234);
    req[1] = 1'b1;
    tick();
    check("b_inplace_ack", 32'(ack), 32'b0010);
    check("b_inplace_data", 32'(disp_data), 32'h1234);
    check("b_inplace_busy", 32'(busy), 32'h1);
    req[1] = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (ack[3] !== 1'b1 && n < 12);
    check("b_ack3_delay", 32'(n), 32'd3);
    check("b_owner3", 32'(owner), 32'd3);
    check("b_data3", 32'(disp_data), 32'h3333);
    req[3] = 1'b0;

    // Sole requester re-requests exactly at the dwell end and gets a fresh dwell.
    do_reset();
    set_word(0, 16'hA0A0);
    req[0] = 1'b1;
    tick();
    check("c_grant_ack", 32'(ack), 32'b0001);
    req[0] = 1'b0;
    repeat (7) tick();
    set_word(0, 16'hC0DE);
    req[0] = 1'b1;
    tick();
    check("c_regrant_ack", 32'(ack), 32'b0001);
    check("c_regrant_data", 32'(disp_data), 32'hC0DE);
    req[0] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("c_dwell_busy", 32'(busy), 32'h1);
    end
    tick();
    check("c_dwell_end", 32'(busy), 32'h0);
    set_word(1, 16'h0B0B);
    req[0] = 1'b1;
    req[1] = 1'b1;
    tick();
    check("c_rr_after", 32'(ack), 32'b0010);
    req = '0;
    tick();

    // Reset in the middle of a dwell with requester 3 pending.
    do_reset();
    set_word(1, 16'h1111);
    req[1] = 1'b1;
    tick();
    req[1] = 1'b0;
    set_word(3, 16'h3333);
    req[3] = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("d_rst_ack", 32'(ack), 32'h0);
    check("d_rst_data", 32'(disp_data), 32'(RW));
    check("d_rst_owner", 32'(owner), 32'h0);
    check("d_rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick();
    check("d_after_ack", 32'(ack), 32'b1000);
    check("d_after_owner", 32'(owner), 32'd3);
    check("d_after_data", 32'(disp_data), 32'h3333);
    req[3] = 1'b0;

    // Randomized protocol-following requesters with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NR; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
          set_word(i, 16'($urandom));
        end
      end
      tick();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
